// File: rtl/adler32_pkg.sv
// Shared constants and types for the adler32 streaming checksum engine.
package adler32_pkg;

    typedef logic [15:0] adler_word_t;

    localparam logic [16:0] ADLER_MOD    = 17'd65521;
    localparam adler_word_t ADLER_A_INIT = 16'd1;
    localparam adler_word_t ADLER_B_INIT = 16'd0;

endpackage

// File: rtl/adler32_mod_add.sv
// Combinational (x + y) mod 65521 for operands that are both already below the modulus.
// Because the operands are reduced, one conditional subtract is always enough.
module adler32_mod_add
    import adler32_pkg::*;
(
    input  adler_word_t i_x,
    input  adler_word_t i_y,
    output adler_word_t o_sum
);

    logic [16:0] w_sum;
    logic [16:0] w_reduced;

    assign w_sum     = {1'b0, i_x} + {1'b0, i_y};
    assign w_reduced = w_sum - ADLER_MOD;
    assign o_sum     = (w_sum >= ADLER_MOD) ? w_reduced[15:0] : w_sum[15:0];

endmodule

// File: rtl/adler32.sv
// Streaming Adler-32 checksum: one byte per clock, result {B,A} pulsed after the last byte.
// Optional build macro ADLER32_RUNNING_EN: checksum shows the running {B,A} after every
// accepted byte instead of only holding completed results.
module adler32
    import adler32_pkg::*;
(
    input  logic        clock,
    input  logic        rst,
    input  logic        data_valid,
    input  logic [7:0]  data,
    input  logic        last_data,
    output logic        checksum_valid,
    output logic [31:0] checksum
);

    adler_word_t r_a;
    adler_word_t r_b;
    logic [31:0] r_checksum;
    logic        r_checksumValid;

    adler_word_t w_aNext;
    adler_word_t w_bNext;

    // A' = A + data, then B' = B + A'; chained so B sees the freshly updated A.
    adler32_mod_add u_addA (
        .i_x   (r_a),
        .i_y   ({8'd0, data}),
        .o_sum (w_aNext)
    );

    adler32_mod_add u_addB (
        .i_x   (r_b),
        .i_y   (w_aNext),
        .o_sum (w_bNext)
    );

    // Accumulate on valid bytes; on the last byte publish the result and rearm for the next message.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_a             <= ADLER_A_INIT;
            r_b             <= ADLER_B_INIT;
            r_checksum      <= 32'h0;
            r_checksumValid <= 1'b0;
        end else begin
            r_checksumValid <= data_valid && last_data;
            if (data_valid) begin
`ifdef ADLER32_RUNNING_EN
                r_checksum <= {w_bNext, w_aNext};
`endif
                if (last_data) begin
                    r_a <= ADLER_A_INIT;
                    r_b <= ADLER_B_INIT;
`ifndef ADLER32_RUNNING_EN
                    r_checksum <= {w_bNext, w_aNext};
`endif
                end else begin
                    r_a <= w_aNext;
                    r_b <= w_bNext;
                end
            end
        end
    end

    assign checksum       = r_checksum;
    assign checksum_valid = r_checksumValid;

endmodule

// File: tb/tb_adler32.sv
// Self-checking bench for adler32: directed messages plus random messages and gaps,
// compared against a plain-arithmetic Adler-32 model. Honors ADLER32_RUNNING_EN.
module tb_adler32;

    typedef logic [7:0] byteQ_t[$];

    logic        clock;
    logic        rst;
    logic        data_valid;
    logic [7:0]  data;
    logic        last_data;
    logic        checksum_valid;
    logic [31:0] checksum;

    int checks;
    int errors;

    // Model state: bytes of the message in flight and the outputs expected right now.
    byteQ_t      curMsg;
    logic [31:0] expChecksum;
    logic        expValid;

    adler32 dut (
        .clock          (clock),
        .rst            (rst),
        .data_valid     (data_valid),
        .data           (data),
        .last_data      (last_data),
        .checksum_valid (checksum_valid),
        .checksum       (checksum)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Adler-32 straight from its definition: A = 1 + sum of bytes, B = sum of every A, both mod 65521.
    function automatic logic [31:0] adlerOf(input byteQ_t msg);
        int a;
        int b;
        a = 1;
        b = 0;
        foreach (msg[i]) begin
            a = (a + int'(msg[i])) % 65521;
            b = (b + a) % 65521;
        end
        return {b[15:0], a[15:0]};
    endfunction

    task automatic checkOutput(input string tag);
        checks++;
        assert (checksum_valid === expValid)
        else begin
            errors++;
            $error("[TB] FAIL %s checksum_valid observed=%b expected=%b", tag, checksum_valid, expValid);
        end
        checks++;
        assert (checksum === expChecksum)
        else begin
            errors++;
            $error("[TB] FAIL %s checksum observed=%h expected=%h", tag, checksum, expChecksum);
        end
    endtask

    // Drive one cycle, advance the model, and compare just after the edge.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l, input string tag);
        data_valid = v;
        data       = d;
        last_data  = l;
        @(posedge clock);
        #1;
        expValid = 1'b0;
        if (v) begin
            curMsg.push_back(d);
`ifdef ADLER32_RUNNING_EN
            expChecksum = adlerOf(curMsg);
`endif
            if (l) begin
                expChecksum = adlerOf(curMsg);
                expValid    = 1'b1;
                curMsg.delete();
            end
        end
        checkOutput(tag);
    endtask

    task automatic applyReset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            data_valid = 1'b1;
            data       = 8'($urandom_range(0, 255));
            last_data  = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
            curMsg.delete();
            expChecksum = 32'h0;
            expValid    = 1'b0;
            checkOutput("reset");
        end
        rst        = 1'b0;
        data_valid = 1'b0;
        last_data  = 1'b0;
    endtask

    // Send a whole message with 0..maxGap idle cycles before each byte; idle cycles carry
    // random data and random last_data, which must both be ignored.
    task automatic sendMessage(input byteQ_t msg, input int maxGap, input logic [31:0] known,
                               input bit useKnown, input string tag);
        for (int i = 0; i < msg.size(); i++) begin
            int gap;
            gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
            for (int g = 0; g < gap; g++)
                applyStimulus(1'b0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), {tag, "_idle"});
            applyStimulus(1'b1, msg[i], (i == msg.size() - 1), tag);
        end
        if (useKnown) begin
            checks++;
            assert (checksum === known)
            else begin
                errors++;
                $error("[TB] FAIL %s_known checksum observed=%h expected=%h", tag, checksum, known);
            end
        end
    endtask

    initial begin
        byteQ_t hello;
        byteQ_t abc;
        byteQ_t single;
        byteQ_t ffs;
        byteQ_t rnd;
        checks      = 0;
        errors      = 0;
        expChecksum = 32'h0;
        expValid    = 1'b0;
        rst         = 1'b0;
        data_valid  = 1'b0;
        data        = 8'h00;
        last_data   = 1'b0;
        hello  = '{8'd72, 8'd101, 8'd108, 8'd108, 8'd111};
        abc    = '{8'h61, 8'h62, 8'h63};
        single = '{8'h61};
        for (int i = 0; i < 257; i++) ffs.push_back(8'hFF);

        #2;
        applyReset(2);

        $display("[TB] Hello with random gaps");
        sendMessage(hello, 9, 32'h058C01F5, 1'b1, "hello_gaps");
        applyStimulus(1'b0, 8'h00, 1'b0, "hello_after");

        $display("[TB] abc then Hello back-to-back");
        sendMessage(abc, 0, 32'h024D0127, 1'b1, "abc_b2b");
        sendMessage(hello, 0, 32'h058C01F5, 1'b1, "hello_b2b");
        applyStimulus(1'b0, 8'h00, 1'b0, "b2b_after");

        $display("[TB] single byte message");
        sendMessage(single, 0, 32'h00620062, 1'b1, "single");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'($urandom_range(0, 255)), 1'b0, "single_hold");

        $display("[TB] 257 x 0xFF wrap");
        sendMessage(ffs, 0, 32'h080F000F, 1'b1, "ff257");

        $display("[TB] reset mid-message");
        applyStimulus(1'b1, hello[0], 1'b0, "abort0");
        applyStimulus(1'b1, hello[1], 1'b0, "abort1");
        applyReset(2);
        sendMessage(abc, 3, 32'h024D0127, 1'b1, "abc_after_reset");

        $display("[TB] stray last_data without data_valid");
        applyStimulus(1'b1, 8'h61, 1'b0, "stray_a");
        applyStimulus(1'b0, 8'h62, 1'b1, "stray_strobe");
        applyStimulus(1'b1, 8'h62, 1'b0, "stray_b");
        applyStimulus(1'b1, 8'h63, 1'b1, "stray_c");
        checks++;
        assert (checksum === 32'h024D0127)
        else begin
            errors++;
            $error("[TB] FAIL stray_known checksum observed=%h expected=%h", checksum, 32'h024D0127);
        end

        $display("[TB] random messages");
        for (int m = 0; m < 8; m++) begin
            rnd.delete();
            for (int i = 0; i < int'($urandom_range(1, 40)); i++)
                rnd.push_back(8'($urandom_range(0, 255)));
            sendMessage(rnd, (m % 2 == 0) ? 0 : 4, 32'h0, 1'b0, "random");
        end
        applyStimulus(1'b0, 8'h00, 1'b0, "final_idle");
        applyStimulus(1'b0, 8'h00, 1'b0, "final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
